// File: rtl/convkxk_mc_core.sv
// Multi-channel KxK convolution core: one MAC per cycle over each channel patch,
// then a single bias add, an arithmetic shift and a ReLU or saturating clamp per output pixel.
//
// state   | meaning
// IDLE    | waiting for start
// WAIT_CH | ch_ready high, waiting for the next channel patch/weights
// MAC     | one product per cycle, previous product accumulated
// DRAIN   | add final product, advance channel index
// BIAS    | add bias once per output
// SHIFT   | arithmetic right shift, clamp into out_data
// OUT     | out_valid held until out_ready
module convkxk_mc_core #(
    parameter int K      = 5,
    parameter int IN_W   = 8,
    parameter int W_W    = 16,
    parameter int B_W    = 16,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int MAX_CH = 16,
    parameter int CH_W   = $clog2(MAX_CH + 1),
    parameter int SH_W   = $clog2(ACC_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CH_W-1:0]         num_ch,
    input  logic [SH_W-1:0]         shift_amt,
    input  logic                    relu_en,
    input  logic signed [B_W-1:0]   bias_val,
    input  logic                    ch_valid,
    output logic                    ch_ready,
    input  logic [K*K*IN_W-1:0]     patch_pixels,
    input  logic [K*K*W_W-1:0]      kernel_weights,
    output logic [CH_W-1:0]         ch_idx,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int NE   = K * K;
    localparam int MC_W = (NE > 1) ? $clog2(NE) : 1;
    localparam int P_W  = IN_W + W_W + 1;

    localparam longint OUT_MAX_L = (longint'(1) << (OUT_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(OUT_MAX_L);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-OUT_MAX_L - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_CH = 3'd1;
    localparam logic [2:0] S_MAC     = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_BIAS    = 3'd4;
    localparam logic [2:0] S_SHIFT   = 3'd5;
    localparam logic [2:0] S_OUT     = 3'd6;

    logic [2:0]              state;
    logic [CH_W-1:0]         nch_q;
    logic [SH_W-1:0]         sh_q;
    logic                    relu_q;
    logic signed [B_W-1:0]   bias_q;
    logic [MC_W-1:0]         mac_cnt;
    logic [IN_W-1:0]         pix_q [NE];
    logic signed [W_W-1:0]   wt_q  [NE];
    logic signed [P_W-1:0]   prod_q;
    logic signed [ACC_W-1:0] acc_q;

    logic signed [P_W-1:0]   pix_ext;
    logic signed [P_W-1:0]   wt_ext;
    logic signed [P_W-1:0]   prod_next;
    logic signed [ACC_W-1:0] shifted;
    logic signed [OUT_W-1:0] sat_val;
    logic [CH_W-1:0]         ch_next;

    assign ch_ready  = (state == S_WAIT_CH);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign ch_next   = ch_idx + CH_W'(1);

    // Pixels are unsigned: a zero MSB makes them non-negative in the signed product.
    always_comb begin
        pix_ext   = P_W'($signed({1'b0, pix_q[mac_cnt]}));
        wt_ext    = P_W'(wt_q[mac_cnt]);
        prod_next = pix_ext * wt_ext;
    end

    assign shifted = acc_q >>> sh_q;

    always_comb begin
        sat_val = shifted[OUT_W-1:0];
        if (relu_q && shifted[ACC_W-1]) begin
            sat_val = '0;
        end else if (shifted > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_W-1:0];
        end else if (!relu_q && (shifted < OUT_MIN)) begin
            sat_val = OUT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            nch_q    <= '0;
            sh_q     <= '0;
            relu_q   <= 1'b0;
            bias_q   <= '0;
            mac_cnt  <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            ch_idx   <= '0;
            out_data <= '0;
            for (int i = 0; i < NE; i++) begin
                pix_q[i] <= '0;
                wt_q[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_ch == '0) begin
                            nch_q <= CH_W'(1);
                        end else if (num_ch > CH_W'(MAX_CH)) begin
                            nch_q <= CH_W'(MAX_CH);
                        end else begin
                            nch_q <= num_ch;
                        end
                        sh_q   <= shift_amt;
                        relu_q <= relu_en;
                        bias_q <= bias_val;
                        acc_q  <= '0;
                        ch_idx <= '0;
                        state  <= S_WAIT_CH;
                    end
                end
                S_WAIT_CH: begin
                    if (ch_valid) begin
                        for (int i = 0; i < NE; i++) begin
                            pix_q[i] <= patch_pixels[i*IN_W +: IN_W];
                            wt_q[i]  <= kernel_weights[i*W_W +: W_W];
                        end
                        mac_cnt <= '0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    prod_q <= prod_next;
                    if (mac_cnt != '0) begin
                        acc_q <= acc_q + ACC_W'(prod_q);
                    end
                    mac_cnt <= mac_cnt + MC_W'(1);
                    if (mac_cnt == MC_W'(NE - 1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    acc_q  <= acc_q + ACC_W'(prod_q);
                    ch_idx <= ch_next;
                    state  <= (ch_next == nch_q) ? S_BIAS : S_WAIT_CH;
                end
                S_BIAS: begin
                    acc_q <= acc_q + ACC_W'(bias_q);
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc_q    <= shifted;
                    out_data <= sat_val;
                    state    <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_convkxk_mc_core.sv
// Directed bench for convkxk_mc_core: expected pixels queued at start, compared when out_valid rises.
module tb_convkxk_mc_core;
    localparam int K     = 5;
    localparam int NE    = K * K;
    localparam int IN_W  = 8;
    localparam int W_W   = 16;
    localparam int CH_W  = 5;
    localparam int SH_W  = 5;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [CH_W-1:0]         num_ch = '0;
    logic [SH_W-1:0]         shift_amt = '0;
    logic                    relu_en = 1'b0;
    logic signed [15:0]      bias_val = '0;
    logic                    ch_valid = 1'b0;
    logic                    ch_ready;
    logic [NE*IN_W-1:0]      patch_pixels = '0;
    logic [NE*W_W-1:0]       kernel_weights = '0;
    logic [CH_W-1:0]         ch_idx;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    busy;

    convkxk_mc_core dut (
        .clk(clk), .rst(rst), .start(start), .num_ch(num_ch), .shift_amt(shift_amt),
        .relu_en(relu_en), .bias_val(bias_val), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .patch_pixels(patch_pixels), .kernel_weights(kernel_weights), .ch_idx(ch_idx),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int hs_cyc = 0;
    int pix_a [NE];
    int wt_a  [NE];
    logic signed [63:0] sb [$];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_uniform(input int p, input int w);
        for (int i = 0; i < NE; i++) begin
            pix_a[i] = p;
            wt_a[i]  = w;
        end
    endtask

    task automatic set_pattern();
        for (int i = 0; i < NE; i++) begin
            pix_a[i] = (i * 13 + 7) % 256;
            wt_a[i]  = ((i * 997) % 4000) - 2000;
        end
    endtask

    function automatic int model(input int n, input int bias, input int sh, input logic relu);
        int s = 0;
        int v;
        for (int i = 0; i < NE; i++) s += pix_a[i] * wt_a[i];
        v = n * s + bias;
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic load_patch();
        for (int i = 0; i < NE; i++) begin
            patch_pixels[i*IN_W +: IN_W] = IN_W'(pix_a[i]);
            kernel_weights[i*W_W +: W_W] = W_W'(wt_a[i]);
        end
    endtask

    task automatic scramble_patch();
        for (int i = 0; i < NE; i++) begin
            patch_pixels[i*IN_W +: IN_W] = IN_W'($urandom);
            kernel_weights[i*W_W +: W_W] = W_W'($urandom);
        end
    endtask

    task automatic start_op(input int n, input int bias, input int sh, input logic relu);
        num_ch    = CH_W'(n);
        bias_val  = 16'(bias);
        shift_amt = SH_W'(sh);
        relu_en   = relu;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        // Config is captured on start, so disturbing it now must not matter.
        num_ch    = CH_W'(7);
        bias_val  = 16'h1234;
        shift_amt = SH_W'(0);
        relu_en   = ~relu;
    endtask

    task automatic do_channel(input int c, input logic hold);
        int t = 0;
        while (!ch_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ch_ready_wait", ch_ready, 1);
        load_patch();
        ch_valid = 1'b1;
        check("ch_idx", ch_idx, c);
        hs_cyc = cyc;
        @(negedge clk);
        check("ch_ready_drop", ch_ready, 0);
        if (!hold) begin
            ch_valid = 1'b0;
            scramble_patch();
        end
    endtask

    task automatic finish_op(input logic stall);
        int t = 0;
        logic signed [63:0] e;
        while (!out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_wait", out_valid, 1);
        check("latency", cyc - hs_cyc, 29);
        e = 64'sd99999;
        if (sb.size() > 0) e = sb.pop_front();
        check("out_data", $signed(out_data), e);
        if (stall) begin
            for (int k = 0; k < 10; k++) begin
                start    = ~start;
                ch_valid = 1'b1;
                @(negedge clk);
                check("stall_valid", out_valid, 1);
                check("stall_data", $signed(out_data), e);
            end
            start     = 1'b0;
            ch_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
    endtask

    task automatic run_op(input int n, input int bias, input int sh, input logic relu,
                          input logic hold, input int expv, input logic stall);
        int eff;
        eff = (n == 0) ? 1 : ((n > 16) ? 16 : n);
        sb.push_back(64'(expv));
        out_ready = !stall;
        start_op(n, bias, sh, relu);
        for (int c = 0; c < eff; c++) do_channel(c, hold);
        ch_valid = 1'b0;
        finish_op(stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_ch_idx", ch_idx, 0);
        rst = 1'b0;

        set_uniform(1, 256);
        run_op(1, 0, 8, 1'b1, 1'b0, 25, 1'b0);
        run_op(3, 0, 8, 1'b1, 1'b1, 75, 1'b0);
        run_op(3, 256, 8, 1'b1, 1'b1, 76, 1'b0);

        set_uniform(1, -256);
        run_op(1, 0, 8, 1'b1, 1'b0, 0, 1'b0);
        run_op(1, 0, 8, 1'b0, 1'b0, -25, 1'b0);

        set_uniform(255, 32767);
        run_op(1, 0, 0, 1'b1, 1'b0, 32767, 1'b0);
        set_uniform(255, -32768);
        run_op(1, 0, 0, 1'b0, 1'b0, -32768, 1'b0);

        set_uniform(1, 256);
        run_op(0, 0, 8, 1'b1, 1'b0, 25, 1'b0);
        run_op(17, 0, 8, 1'b1, 1'b1, 400, 1'b0);

        set_pattern();
        run_op(2, -1000, 4, 1'b0, 1'b0, model(2, -1000, 4, 1'b0), 1'b0);

        set_uniform(1, 256);
        run_op(1, 0, 8, 1'b1, 1'b0, 25, 1'b1);

        // Abort mid-MAC of the second channel; no result may appear.
        out_ready = 1'b1;
        start_op(2, 0, 8, 1'b1);
        do_channel(0, 1'b0);
        do_channel(1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_ch_ready", ch_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", $signed(out_data), 0);
        check("abort_ch_idx", ch_idx, 0);
        rst = 1'b0;
        run_op(1, 0, 8, 1'b1, 1'b0, 25, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
